multi_commit_rob: RTL and testbench



---
 rtl/multi_commit_rob_pkg.sv | 32 +++
 rtl/multi_commit_rob_commit_select.sv | 39 +++
 rtl/multi_commit_rob.sv | 206 ++++++++++++++++++++
 tb/tb_multi_commit_rob.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_commit_rob_pkg.sv
// Shared constants and types for the multi-commit reorder buffer.
//   ROB_NUM / ROB_SEL      : default entry count and index width (index == RRF tag)
//   DEF_*                  : default widths for the top-level parameters
//   rob_flags_t            : per-entry control bits (valid, finished, mispred, dstvalid)
//   popcount8()            : population count of up to 8 request bits
package multi_commit_rob_pkg;

  localparam int ROB_NUM            = 64;
  localparam int ROB_SEL            = $clog2(ROB_NUM);
  localparam int DEF_DISPATCH_WIDTH = 2;
  localparam int DEF_COMMIT_WIDTH   = 2;
  localparam int DEF_NUM_FINISH     = 5;
  localparam int DEF_ADDR_LEN       = 32;
  localparam int DEF_REG_SEL        = 5;

  typedef struct packed {
    logic valid;
    logic finished;
    logic mispred;
    logic dstvalid;
  } rob_flags_t;

  localparam rob_flags_t ROB_FLAGS_EMPTY = '0;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + 4'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/multi_commit_rob_commit_select.sv
// rob_commit_select: decides which of the oldest COMMIT_WIDTH entries retire.
//   win_valid_i    : valid bit of entries head+0 .. head+COMMIT_WIDTH-1
//   win_finished_i : finished bit of the same window
//   win_mispred_i  : mispredicted-branch bit of the same window
//   commit_valid_o : contiguous-from-bit-0 retire mask
//   commit_num_o   : number of retiring entries
module rob_commit_select
  import multi_commit_rob_pkg::*;
#(
  parameter int COMMIT_WIDTH = DEF_COMMIT_WIDTH,
  localparam int CNUM_W      = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic [COMMIT_WIDTH-1:0] win_valid_i,
  input  logic [COMMIT_WIDTH-1:0] win_finished_i,
  input  logic [COMMIT_WIDTH-1:0] win_mispred_i,
  output logic [COMMIT_WIDTH-1:0] commit_valid_o,
  output logic [CNUM_W-1:0]       commit_num_o
);

  logic stop;

  // Retirement is strictly in order; a retiring mispredicted branch is the
  // last one to go this cycle because everything younger is on the wrong path.
  always_comb begin
    commit_valid_o = '0;
    commit_num_o   = '0;
    stop           = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (!stop && win_valid_i[i] && win_finished_i[i]) begin
        commit_valid_o[i] = 1'b1;
        commit_num_o      = commit_num_o + CNUM_W'(1);
        if (win_mispred_i[i]) stop = 1'b1;
      end else begin
        stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_commit_rob.sv
// multi_commit_rob: reorder buffer with multi-slot dispatch and commit.
//   clk_i, reset_i            : clock, synchronous active-high reset
//   dp_*                      : dispatch slots (contiguous valid, pc, dst)
//   alloc_ptr_o / free_num_o  : tail index and free-entry count
//   allocatable_o             : at least DISPATCH_WIDTH entries free
//   finish_*                  : completion strobes; last port is the branch port
//   br_mispred_i/br_target_i  : branch-port misprediction and corrected PC
//   commit_*/arfwe_o/dst_arf_o: in-order retirement to ARF/RRF
//   flush_o / flush_pc_o      : registered redirect one cycle after a mispredict retires
module multi_commit_rob
  import multi_commit_rob_pkg::*;
#(
  parameter int ROB_DEPTH      = ROB_NUM,
  parameter int DISPATCH_WIDTH = DEF_DISPATCH_WIDTH,
  parameter int COMMIT_WIDTH   = DEF_COMMIT_WIDTH,
  parameter int NUM_FINISH     = DEF_NUM_FINISH,
  parameter int ADDR_LEN       = DEF_ADDR_LEN,
  parameter int REG_SEL        = DEF_REG_SEL,
  localparam int SEL           = $clog2(ROB_DEPTH),
  localparam int CNT_W         = SEL + 1,
  localparam int CNUM_W        = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [DISPATCH_WIDTH-1:0]         dp_valid_i,
  input  logic [DISPATCH_WIDTH*ADDR_LEN-1:0] dp_pc_i,
  input  logic [DISPATCH_WIDTH-1:0]         dp_dstvalid_i,
  input  logic [DISPATCH_WIDTH*REG_SEL-1:0] dp_dst_i,
  output logic [SEL-1:0]                    alloc_ptr_o,
  output logic                              allocatable_o,
  output logic [CNT_W-1:0]                  free_num_o,
  input  logic [NUM_FINISH-1:0]             finish_valid_i,
  input  logic [NUM_FINISH*SEL-1:0]         finish_addr_i,
  input  logic                              br_mispred_i,
  input  logic [ADDR_LEN-1:0]               br_target_i,
  output logic [COMMIT_WIDTH-1:0]           commit_valid_o,
  output logic [COMMIT_WIDTH*SEL-1:0]       commit_ptr_o,
  output logic [COMMIT_WIDTH-1:0]           arfwe_o,
  output logic [COMMIT_WIDTH*REG_SEL-1:0]   dst_arf_o,
  output logic [CNUM_W-1:0]                 commit_num_o,
  output logic                              flush_o,
  output logic [ADDR_LEN-1:0]               flush_pc_o
);

  rob_flags_t          flags_q  [ROB_DEPTH];
  rob_flags_t          flags_d  [ROB_DEPTH];
  logic [REG_SEL-1:0]  dst_q    [ROB_DEPTH];
  logic [REG_SEL-1:0]  dst_d    [ROB_DEPTH];
  logic [ADDR_LEN-1:0] target_q [ROB_DEPTH];
  logic [ADDR_LEN-1:0] target_d [ROB_DEPTH];

  logic [SEL-1:0]      head_q, head_d;
  logic [SEL-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                flush_q, flush_d;
  logic [ADDR_LEN-1:0] flush_pc_q, flush_pc_d;

  logic [SEL-1:0]          commit_idx [COMMIT_WIDTH];
  logic [SEL-1:0]          disp_idx   [DISPATCH_WIDTH];
  logic [COMMIT_WIDTH-1:0] win_valid, win_finished, win_mispred, win_dstvalid;
  logic [COMMIT_WIDTH-1:0] commit_valid;
  logic [CNUM_W-1:0]       commit_num;
  logic                    dp_accept;
  logic [3:0]              dp_n;

  // The redirect comes from the branch target, so the dispatch PC is not
  // needed to retire anything.
  logic unused_dp_pc;
  assign unused_dp_pc = ^dp_pc_i;

  assign free_num_o    = CNT_W'(ROB_DEPTH) - count_q;
  assign allocatable_o = (free_num_o >= CNT_W'(DISPATCH_WIDTH));
  assign alloc_ptr_o   = tail_q;
  assign dp_accept     = allocatable_o;
  assign dp_n          = dp_accept ? popcount8(8'(dp_valid_i)) : 4'd0;
  assign flush_o       = flush_q;
  assign flush_pc_o    = flush_pc_q;

  always_comb begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      commit_idx[i]   = head_q + SEL'(i);
      win_valid[i]    = flags_q[commit_idx[i]].valid;
      win_finished[i] = flags_q[commit_idx[i]].finished;
      win_mispred[i]  = flags_q[commit_idx[i]].mispred;
      win_dstvalid[i] = flags_q[commit_idx[i]].dstvalid;
    end
    for (int k = 0; k < DISPATCH_WIDTH; k++) disp_idx[k] = tail_q + SEL'(k);
  end

  rob_commit_select #(
    .COMMIT_WIDTH (COMMIT_WIDTH)
  ) u_commit_select (
    .win_valid_i    (win_valid),
    .win_finished_i (win_finished),
    .win_mispred_i  (win_mispred),
    .commit_valid_o (commit_valid),
    .commit_num_o   (commit_num)
  );

  // Non-retiring slots drive zeros so the ARF/RRF sees clean buses.
  always_comb begin
    commit_valid_o = commit_valid;
    commit_num_o   = commit_num;
    commit_ptr_o   = '0;
    arfwe_o        = '0;
    dst_arf_o      = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (commit_valid[i]) begin
        commit_ptr_o[i*SEL +: SEL]       = commit_idx[i];
        arfwe_o[i]                       = win_dstvalid[i];
        dst_arf_o[i*REG_SEL +: REG_SEL]  = dst_q[commit_idx[i]];
      end
    end
  end

  always_comb begin
    flags_d    = flags_q;
    dst_d      = dst_q;
    target_d   = target_q;
    flush_d    = 1'b0;
    flush_pc_d = flush_pc_q;

    // Retire: clear the entries leaving the head.
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (commit_valid[i]) begin
        flags_d[commit_idx[i]] = ROB_FLAGS_EMPTY;
        if (win_mispred[i]) begin
          flush_d    = 1'b1;
          flush_pc_d = target_q[commit_idx[i]];
        end
      end
    end

    // Finish: checked against post-retire state so a stale strobe cannot
    // resurrect a slot that just left or was never allocated.
    for (int p = 0; p < NUM_FINISH; p++) begin
      if (finish_valid_i[p] && flags_d[finish_addr_i[p*SEL +: SEL]].valid) begin
        flags_d[finish_addr_i[p*SEL +: SEL]].finished = 1'b1;
        if (p == NUM_FINISH - 1) begin
          flags_d[finish_addr_i[p*SEL +: SEL]].mispred = br_mispred_i;
          target_d[finish_addr_i[p*SEL +: SEL]]        = br_target_i;
        end
      end
    end

    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (dp_accept && dp_valid_i[k]) begin
        flags_d[disp_idx[k]].valid    = 1'b1;
        flags_d[disp_idx[k]].finished = 1'b0;
        flags_d[disp_idx[k]].mispred  = 1'b0;
        flags_d[disp_idx[k]].dstvalid = dp_dstvalid_i[k];
        dst_d[disp_idx[k]]            = dp_dst_i[k*REG_SEL +: REG_SEL];
      end
    end

    head_d  = head_q + SEL'(commit_num);
    tail_d  = tail_q + SEL'(dp_n);
    count_d = count_q + CNT_W'(dp_n) - CNT_W'(commit_num);

    // A retiring mispredict squashes everything, including this cycle's
    // dispatches and finishes, which all belong to the wrong path.
    if (flush_d) begin
      for (int j = 0; j < ROB_DEPTH; j++) flags_d[j] = ROB_FLAGS_EMPTY;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int j = 0; j < ROB_DEPTH; j++) flags_q[j] <= ROB_FLAGS_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      flags_q    <= flags_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    dst_q    <= dst_d;
    target_q <= target_d;
  end

  a_dp_full: assert property (@(posedge clk_i) disable iff (reset_i)
    !(|dp_valid_i && !allocatable_o));
  a_dp_flush: assert property (@(posedge clk_i) disable iff (reset_i)
    !(|dp_valid_i && flush_o));

  for (genvar p = 0; p < NUM_FINISH; p++) begin : g_fin_a
    for (genvar q = p + 1; q < NUM_FINISH; q++) begin : g_fin_b
      a_fin_dup: assert property (@(posedge clk_i) disable iff (reset_i)
        !(finish_valid_i[p] && finish_valid_i[q] &&
          finish_addr_i[p*SEL +: SEL] == finish_addr_i[q*SEL +: SEL]));
    end
  end

endmodule

// File: tb/tb_multi_commit_rob.sv
// Self-checking bench for multi_commit_rob (default parameters).
// A queue-based reference model tracks the in-flight instructions in
// program order; a single negedge process compares every DUT output
// against it and then advances it with the inputs the DUT will see at
// the next rising edge. Directed checks pin a few literal values.
module tb_multi_commit_rob;

  localparam int DEPTH = 64, DW = 2, CW = 2, NF = 5, AL = 32, RS = 5, SEL = 6, CNW = 2;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic [DW-1:0]     dp_valid_i = '0;
  logic [DW*AL-1:0]  dp_pc_i = '0;
  logic [DW-1:0]     dp_dstvalid_i = '0;
  logic [DW*RS-1:0]  dp_dst_i = '0;
  logic [SEL-1:0]    alloc_ptr_o;
  logic              allocatable_o;
  logic [SEL:0]      free_num_o;
  logic [NF-1:0]     finish_valid_i = '0;
  logic [NF*SEL-1:0] finish_addr_i = '0;
  logic              br_mispred_i = 1'b0;
  logic [AL-1:0]     br_target_i = '0;
  logic [CW-1:0]     commit_valid_o;
  logic [CW*SEL-1:0] commit_ptr_o;
  logic [CW-1:0]     arfwe_o;
  logic [CW*RS-1:0]  dst_arf_o;
  logic [CNW-1:0]    commit_num_o;
  logic              flush_o;
  logic [AL-1:0]     flush_pc_o;

  multi_commit_rob dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dp_valid_i(dp_valid_i), .dp_pc_i(dp_pc_i), .dp_dstvalid_i(dp_dstvalid_i), .dp_dst_i(dp_dst_i),
    .alloc_ptr_o(alloc_ptr_o), .allocatable_o(allocatable_o), .free_num_o(free_num_o),
    .finish_valid_i(finish_valid_i), .finish_addr_i(finish_addr_i),
    .br_mispred_i(br_mispred_i), .br_target_i(br_target_i),
    .commit_valid_o(commit_valid_o), .commit_ptr_o(commit_ptr_o), .arfwe_o(arfwe_o),
    .dst_arf_o(dst_arf_o), .commit_num_o(commit_num_o),
    .flush_o(flush_o), .flush_pc_o(flush_pc_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions oldest first.
  typedef struct {
    int          idx;
    bit          dv;
    logic [4:0]  dst;
    bit          fin;
    bit          mp;
    logic [31:0] tgt;
  } ment_t;

  ment_t       mq[$];
  int          m_tail = 0;
  bit          m_flush = 0;
  logic [31:0] m_fpc = '0;
  bit          mdl_on = 0;

  always @(negedge clk_i) begin
    logic [CW-1:0]     e_cv, e_we;
    logic [CW*SEL-1:0] e_cp;
    logic [CW*RS-1:0]  e_dd;
    int                n, fr;
    bit                br;
    logic [31:0]       bt;
    ment_t             e;

    // Retire set: oldest run of finished entries, ending early after a mispredict.
    e_cv = '0; e_we = '0; e_cp = '0; e_dd = '0; n = 0; br = 0; bt = '0;
    while (n < CW && n < mq.size() && mq[n].fin && !br) begin
      e_cv[n] = 1'b1;
      e_we[n] = mq[n].dv;
      e_cp[n*SEL +: SEL] = 6'(mq[n].idx);
      e_dd[n*RS +: RS] = mq[n].dst;
      if (mq[n].mp) begin br = 1; bt = mq[n].tgt; end
      n++;
    end
    fr = DEPTH - mq.size();

    if (mdl_on) begin
      chk("commit_valid", 64'(commit_valid_o), 64'(e_cv));
      chk("commit_num",   64'(commit_num_o),   64'(n));
      chk("commit_ptr",   64'(commit_ptr_o),   64'(e_cp));
      chk("arfwe",        64'(arfwe_o),        64'(e_we));
      chk("dst_arf",      64'(dst_arf_o),      64'(e_dd));
      chk("alloc_ptr",    64'(alloc_ptr_o),    64'(m_tail));
      chk("free_num",     64'(free_num_o),     64'(fr));
      chk("allocatable",  64'(allocatable_o),  64'(fr >= DW));
      chk("flush",        64'(flush_o),        64'(m_flush));
      chk("flush_pc",     64'(flush_pc_o),     64'(m_fpc));
    end

    // Advance to the state after the coming rising edge.
    if (reset_i) begin
      mq.delete(); m_tail = 0; m_flush = 0; m_fpc = '0; mdl_on = 1;
    end else if (mdl_on) begin
      if (br) begin
        mq.delete(); m_tail = 0; m_flush = 1; m_fpc = bt;
      end else begin
        m_flush = 0;
        repeat (n) void'(mq.pop_front());
        for (int p = 0; p < NF; p++) begin
          if (finish_valid_i[p]) begin
            foreach (mq[j]) begin
              if (mq[j].idx == int'(finish_addr_i[p*SEL +: SEL])) begin
                mq[j].fin = 1;
                if (p == NF - 1) begin mq[j].mp = br_mispred_i; mq[j].tgt = br_target_i; end
              end
            end
          end
        end
        if (fr >= DW) begin
          for (int k = 0; k < DW; k++) begin
            if (dp_valid_i[k]) begin
              e.idx = m_tail; e.dv = dp_dstvalid_i[k]; e.dst = dp_dst_i[k*RS +: RS];
              e.fin = 0; e.mp = 0; e.tgt = '0;
              mq.push_back(e);
              m_tail = (m_tail + 1) % DEPTH;
            end
          end
        end
      end
    end
  end

  int dsrc = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
    dp_valid_i = '0; dp_dstvalid_i = '0; finish_valid_i = '0; br_mispred_i = 1'b0;
  endtask

  task automatic disp2();
    dp_valid_i    = 2'b11;
    dp_dstvalid_i = {dsrc[1], 1'b1};
    dp_dst_i      = {5'(dsrc + 1), 5'(dsrc)};
    dp_pc_i       = {32'(32'h1000 + 4 * (dsrc + 1)), 32'(32'h1000 + 4 * dsrc)};
    dsrc += 2;
  endtask

  task automatic fin(input int p, input int a);
    finish_valid_i[p] = 1'b1;
    finish_addr_i[p*SEL +: SEL] = 6'(a);
  endtask

  initial begin
    // Reset values
    tick(); tick();
    reset_i = 1'b0;
    chk("rst_alloc_ptr",   64'(alloc_ptr_o),    64'd0);
    chk("rst_free_num",    64'(free_num_o),     64'd64);
    chk("rst_allocatable", 64'(allocatable_o),  64'd1);
    chk("rst_commit_ptr",  64'(commit_ptr_o),   64'd0);
    chk("rst_flush",       64'(flush_o),        64'd0);

    // Four double dispatches, nothing finished
    repeat (4) begin disp2(); tick(); end
    chk("d4_alloc_ptr",    64'(alloc_ptr_o),    64'd8);
    chk("d4_free_num",     64'(free_num_o),     64'd56);
    chk("d4_commit_valid", 64'(commit_valid_o), 64'd0);

    // Fill to 64
    repeat (28) begin disp2(); tick(); end
    chk("full_allocatable", 64'(allocatable_o), 64'd0);
    chk("full_free_num",    64'(free_num_o),    64'd0);
    chk("full_alloc_ptr",   64'(alloc_ptr_o),   64'd0);

    // Out-of-order finish: 1,2 first, then 0
    fin(0, 1); fin(1, 2); tick();
    chk("ooo_no_commit",   64'(commit_num_o),   64'd0);
    fin(2, 0); tick();
    chk("ooo_commit_num",  64'(commit_num_o),   64'd2);
    chk("ooo_commit_ptr",  64'(commit_ptr_o),   64'h40);   // {1,0}
    tick();
    chk("ooo_commit2_ptr", 64'(commit_ptr_o),   64'd2);
    chk("ooo_commit2_num", 64'(commit_num_o),   64'd1);
    chk("ooo_free_num",    64'(free_num_o),     64'd2);
    chk("ooo_allocatable", 64'(allocatable_o),  64'd1);
    tick();

    // Drain 3..62 two per cycle, refill entries 0,1, then wrap at head 63
    for (int a = 3; a < 63; a += 2) begin
      if (a == 3) disp2();
      fin(0, a); fin(1, a + 1); tick();
    end
    tick(); tick();
    br_target_i = 32'h1234;
    fin(0, 63); fin(1, 0); fin(4, 1); tick();
    chk("wrap_commit_ptr", 64'(commit_ptr_o),   64'd63);   // {0,63}
    chk("wrap_commit_num", 64'(commit_num_o),   64'd2);
    tick();
    chk("wrap_head_ptr",   64'(commit_ptr_o),   64'd1);
    chk("wrap_head_valid", 64'(commit_valid_o), 64'd1);
    tick();

    // Mispredicted branch at entry 3
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    repeat (3) begin disp2(); tick(); end
    fin(0, 0); fin(1, 1); fin(2, 2); tick();
    tick(); tick();
    br_mispred_i = 1'b1; br_target_i = 32'h80;
    fin(4, 3); fin(0, 4); tick();
    chk("br_commit_num",   64'(commit_num_o),   64'd1);
    chk("br_commit_ptr",   64'(commit_ptr_o),   64'd3);
    disp2(); fin(1, 5); tick();
    chk("br_flush",        64'(flush_o),        64'd1);
    chk("br_flush_pc",     64'(flush_pc_o),     64'h80);
    chk("br_free_num",     64'(free_num_o),     64'd64);
    chk("br_alloc_ptr",    64'(alloc_ptr_o),    64'd0);
    tick();
    chk("br_flush_pulse",  64'(flush_o),        64'd0);

    // Reset overrides a pending flush with 10 entries in flight
    repeat (5) begin disp2(); tick(); end
    br_mispred_i = 1'b1; br_target_i = 32'h44;
    fin(4, 0); tick();
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    chk("rr_flush",        64'(flush_o),        64'd0);
    chk("rr_flush_pc",     64'(flush_pc_o),     64'd0);
    chk("rr_free_num",     64'(free_num_o),     64'd64);
    chk("rr_alloc_ptr",    64'(alloc_ptr_o),    64'd0);
    chk("rr_commit_valid", 64'(commit_valid_o), 64'd0);
    tick();
    chk("rr_flush_after",  64'(flush_o),        64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
